uart_rx: RTL and testbench

UART receiver for the Spartan-6 UART path: recovers 8N1 serial frames from the `rxd` line into parallel bytes. It runs on the oversampling `baud_clk` at 16× the bit rate, and presents each byte through a valid/ack holding register with error flags. It is the receive counterpart to the existing UART transmitter and shares its frame format: start 0, 8 data bits LSB first, stop 1.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_if.sv | 32 +++
 rtl/uart_rx_sync.sv | 36 +++
 rtl/uart_rx.sv | 174 +++++++++++++++++
 tb/tb_uart_rx.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared types and defaults for the UART receive path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int OVERSAMPLE_DEF  = 16;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DATA_BITS       = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    WAIT_HI = 3'd5
  } rx_state_e;

  // Value the parity bit must carry for the whole frame to have even parity.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_if.sv
// ============================================================================
// Module   : uart_rx_if
// Brief    : Serial line plus valid/ack byte handshake of the UART receiver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_if;
  import uart_pkg::*;

  logic                 rxd;
  logic                 ack;
  logic [DATA_BITS-1:0] dout;
  logic                 valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output rxd, ack,
    input  dout, valid, frame_err, parity_err, overrun, busy
  );

  modport slave (
    input  rxd, ack,
    output dout, valid, frame_err, parity_err, overrun, busy
  );

endinterface

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module   : uart_rx_sync
// Brief    : Flop chain bringing the asynchronous rxd line into baud_clk;
//            resets to the idle (high) line level.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic baud_clk,
  input  logic rst,
  input  logic rxd,
  output logic rxs
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  if (SYNC_STAGES > 1) begin : g_chain
    always_comb sync_d = {sync_q[SYNC_STAGES-2:0], rxd};
  end else begin : g_single
    always_comb sync_d = rxd;
  end

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= sync_d;
  end

  assign rxs = sync_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Brief    : Oversampling 8N1 UART receiver with valid/ack holding register.
//            Define UART_RX_PARITY_EN for 8E1 frames with a live parity_err.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input logic     baud_clk,
  input logic     rst,
  uart_rx_if.slave bus
);

  localparam int            TW       = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

  logic rxs;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .baud_clk(baud_clk),
    .rst     (rst),
    .rxd     (bus.rxd),
    .rxs     (rxs)
  );

  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;
  logic                 par_load;

  wire tick_mid = (tick_q == TICK_MID);
  wire tick_end = (tick_q == TICK_END);
  wire deliver  = (state_q == STOP) && tick_end;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end

  always_comb begin
    par_d = par_q;
    if (state_q == PARITY && tick_end) par_d = rxs ^ even_parity(shreg_q);
  end

  assign par_load = par_q;
`else
  assign par_load = 1'b0;
`endif

  always_ff @(posedge baud_clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!rxs) state_d = START;
      START:   if (tick_mid) state_d = rxs ? IDLE : DATA;
      DATA: begin
        if (tick_end && bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY:  if (tick_end) state_d = STOP;
`endif
      // A low stop sample may be a break; hold off until the line recovers.
      STOP:    if (tick_end) state_d = rxs ? IDLE : WAIT_HI;
      WAIT_HI: if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tick_d    = tick_q + 1'b1;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    dout_d    = dout_q;
    valid_d   = valid_q;
    ferr_d    = ferr_q;
    perr_d    = perr_q;
    overrun_d = overrun_q;
    busy_d    = (state_d != IDLE);

    case (state_q)
      IDLE: if (!rxs) tick_d = '0;
      START: begin
        if (tick_mid && !rxs) begin
          tick_d = '0;
          bit_d  = '0;
        end
      end
      DATA: begin
        if (tick_end) begin
          shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
        end
      end
      default: ;
    endcase

    // An ack on the delivery edge frees the register for the new byte.
    if (deliver) begin
      if (!valid_q || bus.ack) begin
        dout_d  = shreg_q;
        ferr_d  = ~rxs;
        perr_d  = par_load;
        valid_d = 1'b1;
        if (bus.ack) overrun_d = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (bus.ack && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.valid      = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.parity_err = perr_q;
  assign bus.overrun    = overrun_q;
  assign bus.busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed bench for uart_rx (default 8N1 or UART_RX_PARITY_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;
  import uart_pkg::*;

  localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int EXP_LAT   = 170;
  localparam int PAR_TICKS = OS;
`else
  localparam int EXP_LAT   = 154;
  localparam int PAR_TICKS = 0;
`endif

  logic baud_clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_bad   = 0;
  int   lat;

  uart_rx_if u_if ();

  uart_rx #(
    .OVERSAMPLE (OS),
    .SYNC_STAGES(2)
  ) dut (
    .baud_clk(baud_clk),
    .rst     (rst),
    .bus     (u_if.slave)
  );

  always #5 baud_clk = ~baud_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge baud_clk);
  endtask

  task automatic line(input logic v, input int n);
    u_if.rxd = v;
    ticks(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop_v,
                            input int stop_ticks);
    line(1'b0, OS);
    for (int i = 0; i < 8; i++) line(d[i], OS);
    line(pbit, PAR_TICKS);
    line(stop_v, stop_ticks);
    u_if.rxd = 1'b1;
  endtask

  // Counts posedges from the first one that can sample the start bit.
  task automatic wait_valid(input int max_edges, output int l);
    l = -1;
    for (int c = 0; c < max_edges; c++) begin
      @(posedge baud_clk);
      #1;
      if (u_if.valid) begin
        l = c;
        return;
      end
    end
  endtask

  task automatic recv(input logic [7:0] d, input logic pbit, input logic stop_v,
                      input int stop_ticks, output int l);
    int lw;
    fork
      send_frame(d, pbit, stop_v, stop_ticks);
      wait_valid(400, lw);
    join
    l = lw;
  endtask

  task automatic ack_pulse(input string tag);
    @(negedge baud_clk);
    u_if.ack = 1'b1;
    @(posedge baud_clk);
    #1;
    u_if.ack = 1'b0;
    check({tag, "_ack_valid"}, u_if.valid, 1'b0);
    check({tag, "_ack_ovr"}, u_if.overrun, 1'b0);
    @(negedge baud_clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst      = 1'b1;
    u_if.rxd = 1'b1;
    u_if.ack = 1'b0;
    ticks(3);
    check("rst_valid", u_if.valid, 1'b0);
    check("rst_dout", u_if.dout, 8'h00);
    check("rst_busy", u_if.busy, 1'b0);
    check("rst_ovr", u_if.overrun, 1'b0);
    check("rst_ferr", u_if.frame_err, 1'b0);
    check("rst_perr", u_if.parity_err, 1'b0);
    rst = 1'b0;
    ticks(4);

    // 0xA5 with latency and mid-frame busy
    fork
      send_frame(8'hA5, even_parity(8'hA5), 1'b1, OS);
      begin
        wait_valid(400, lat);
        check("a5_latency", lat, EXP_LAT);
        check("a5_dout", u_if.dout, 8'hA5);
        check("a5_ferr", u_if.frame_err, 1'b0);
        check("a5_perr", u_if.parity_err, 1'b0);
        check("a5_busy_end", u_if.busy, 1'b0);
      end
      begin
        ticks(60);
        check("a5_busy_mid", u_if.busy, 1'b1);
      end
    join
    ack_pulse("a5");

    // 4-tick glitch is a false start
    line(1'b0, 4);
    line(1'b1, 30);
    check("glitch_valid", u_if.valid, 1'b0);
    check("glitch_busy", u_if.busy, 1'b0);
    recv(8'h3C, even_parity(8'h3C), 1'b1, OS, lat);
    check("3c_seen", lat >= 0, 1'b1);
    check("3c_dout", u_if.dout, 8'h3C);
    ack_pulse("3c");

    // stop bit held low for two bit times
    recv(8'h81, even_parity(8'h81), 1'b0, 2 * OS, lat);
    check("81_seen", lat >= 0, 1'b1);
    check("81_dout", u_if.dout, 8'h81);
    check("81_ferr", u_if.frame_err, 1'b1);
    ack_pulse("81");
    ticks(200);
    check("81_no_retrigger", u_if.valid, 1'b0);
    check("81_idle", u_if.busy, 1'b0);

    // overrun: two frames, no ack
    send_frame(8'h11, even_parity(8'h11), 1'b1, OS);
    send_frame(8'h22, even_parity(8'h22), 1'b1, OS);
    ticks(4);
    check("ovr_valid", u_if.valid, 1'b1);
    check("ovr_dout", u_if.dout, 8'h11);
    check("ovr_flag", u_if.overrun, 1'b1);
    ack_pulse("ovr");

    // async reset during bit 4 of 0xFF
    fork
      send_frame(8'hFF, even_parity(8'hFF), 1'b1, OS);
      begin
        ticks(OS * 5 + 8);
        check("mid_busy", u_if.busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("mrst_valid", u_if.valid, 1'b0);
        check("mrst_busy", u_if.busy, 1'b0);
        check("mrst_dout", u_if.dout, 8'h00);
        check("mrst_ovr", u_if.overrun, 1'b0);
        check("mrst_ferr", u_if.frame_err, 1'b0);
        @(negedge baud_clk);
        rst = 1'b0;
      end
    join
    ticks(20);
    check("mrst_no_partial", u_if.valid, 1'b0);
    recv(8'h5A, even_parity(8'h5A), 1'b1, OS, lat);
    check("5a_latency", lat, EXP_LAT);
    check("5a_dout", u_if.dout, 8'h5A);
    check("5a_ferr", u_if.frame_err, 1'b0);
    ack_pulse("5a");

`ifdef UART_RX_PARITY_EN
    recv(8'h07, 1'b0, 1'b1, OS, lat);
    check("p07_bad_dout", u_if.dout, 8'h07);
    check("p07_bad_perr", u_if.parity_err, 1'b1);
    ack_pulse("p07_bad");
    recv(8'h07, 1'b1, 1'b1, OS, lat);
    check("p07_good_dout", u_if.dout, 8'h07);
    check("p07_good_perr", u_if.parity_err, 1'b0);
    ack_pulse("p07_good");
`else
    recv(8'h07, 1'b0, 1'b1, OS, lat);
    check("n07_dout", u_if.dout, 8'h07);
    check("n07_perr", u_if.parity_err, 1'b0);
    ack_pulse("n07");
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
